// File: rtl/ghost_pkg.sv
// Shared types and constants for the ghost scheduler slice.
package ghost_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    MODE_SCATTER = 2'b00,
    MODE_CHASE   = 2'b01,
    MODE_FRIGHT  = 2'b10
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_UPD  = 2'b10
  } sched_state_t;

  // Scatter corners; ghosts beyond the fourth wrap around this table.
  localparam int unsigned NUM_CORNERS = 4;
  localparam logic [7:0] SCATTER_X [NUM_CORNERS] = '{8'd25, 8'd2, 8'd27, 8'd0};
  localparam logic [7:0] SCATTER_Y [NUM_CORNERS] = '{8'd0, 8'd0, 8'd31, 8'd31};

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting towards the MSB.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/ghost_mode_timer.sv
// Global scatter/chase/fright mode timer, advanced only by accepted ticks.
// Optional frightened mode is built when GHOST_FRIGHT_EN is defined.
module ghost_mode_timer
  import ghost_pkg::*;
#(
  parameter int unsigned SCATTER_TICKS = 70,
  parameter int unsigned CHASE_TICKS   = 200,
  parameter int unsigned NUM_PHASES    = 4,
  parameter int unsigned FRIGHT_TICKS  = 60
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  i_tick,
  input  logic  i_pellet,
  output mode_t o_tick_mode
);

  localparam int unsigned MAX_SC = (SCATTER_TICKS > CHASE_TICKS) ? SCATTER_TICKS : CHASE_TICKS;
  localparam int unsigned MAX_T  = (MAX_SC > FRIGHT_TICKS) ? MAX_SC : FRIGHT_TICKS;
  localparam int unsigned CNT_W  = $clog2(MAX_T) + 1;
  localparam int unsigned PH_W   = $clog2(NUM_PHASES + 1);

  mode_t             r_sc_mode;
  logic [CNT_W-1:0]  r_cnt;
  logic [PH_W-1:0]   r_phase;
  logic              w_hold;
  logic              w_sc_adv;

  assign w_hold = (r_phase == PH_W'(NUM_PHASES));

`ifdef GHOST_FRIGHT_EN
  logic             r_fright;
  logic [CNT_W-1:0] r_fcnt;
  logic             w_fright_eff;
  logic [CNT_W-1:0] w_fcnt_eff;

  // A pellet in the same cycle as a tick is applied before the tick.
  assign w_fright_eff = r_fright | i_pellet;
  assign w_fcnt_eff   = i_pellet ? CNT_W'(FRIGHT_TICKS) : r_fcnt;
  assign o_tick_mode  = w_fright_eff ? MODE_FRIGHT : r_sc_mode;
  assign w_sc_adv     = i_tick && !w_fright_eff;

  // Fright countdown; each fright tick consumes one count, pellets reload it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fright <= 1'b0;
      r_fcnt   <= '0;
    end else if (i_tick && w_fright_eff) begin
      if (w_fcnt_eff <= CNT_W'(1)) begin
        r_fright <= 1'b0;
        r_fcnt   <= '0;
      end else begin
        r_fright <= 1'b1;
        r_fcnt   <= w_fcnt_eff - 1'b1;
      end
    end else if (i_pellet) begin
      r_fright <= 1'b1;
      r_fcnt   <= CNT_W'(FRIGHT_TICKS);
    end
  end
`else
  logic w_unused_pellet;

  assign w_unused_pellet = i_pellet;
  assign o_tick_mode     = r_sc_mode;
  assign w_sc_adv        = i_tick;
`endif

  // Scatter/chase phase sequencing; CHASE holds once all phases are spent.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sc_mode <= MODE_SCATTER;
      r_cnt     <= '0;
      r_phase   <= '0;
    end else if (w_sc_adv) begin
      case (r_sc_mode)
        MODE_SCATTER: begin
          if (r_cnt + 1'b1 == CNT_W'(SCATTER_TICKS)) begin
            r_sc_mode <= MODE_CHASE;
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        MODE_CHASE: begin
          if (!w_hold) begin
            if (r_cnt + 1'b1 == CNT_W'(CHASE_TICKS)) begin
              r_cnt     <= '0;
              r_phase   <= r_phase + 1'b1;
              r_sc_mode <= (r_phase + 1'b1 == PH_W'(NUM_PHASES)) ? MODE_CHASE : MODE_SCATTER;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ghost_scheduler.sv
// Time-shares one ghost direction unit across NUM_GHOSTS ghosts per game tick.
// Frightened mode and its LFSR targets are built when GHOST_FRIGHT_EN is defined.
module ghost_scheduler
  import ghost_pkg::*;
#(
  parameter  int unsigned COORD_W       = 5,
  parameter  int unsigned NUM_GHOSTS    = 4,
  parameter  int unsigned SCATTER_TICKS = 70,
  parameter  int unsigned CHASE_TICKS   = 200,
  parameter  int unsigned NUM_PHASES    = 4,
  parameter  int unsigned FRIGHT_TICKS  = 60,
  localparam int unsigned SEL_W         = $clog2(NUM_GHOSTS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  powerPellet,
  input  logic [COORD_W-1:0]    pacPosX,
  input  logic [COORD_W-1:0]    pacPosY,
  output logic                  req,
  input  logic                  ack,
  input  logic [1:0]            dirIn,
  output logic [SEL_W-1:0]      ghostSel,
  output logic [COORD_W-1:0]    targetPosX,
  output logic [COORD_W-1:0]    targetPosY,
  output logic [NUM_GHOSTS-1:0] ghostUpdate,
  output logic [1:0]            ghostDir,
  output logic [1:0]            mode,
  output logic                  busy,
  output logic                  overrun
);

  sched_state_t        r_state, w_next;
  logic [SEL_W-1:0]    r_sel, w_next_sel;
  logic [COORD_W-1:0]  r_tx, r_ty, w_tgt_x, w_tgt_y;
  mode_t               r_cur_mode, r_pend_mode, w_tick_mode, w_sw_mode;
  logic [COORD_W-1:0]  r_cur_px, r_cur_py, r_pend_px, r_pend_py, w_sw_px, w_sw_py;
  logic                r_pending, r_overrun;
  dir_t                r_dir;
  logic                w_busy, w_last, w_start, w_tick_acc, w_to_pend, w_enter_req;
  logic [1:0]          w_corner;

  assign w_busy      = (r_state != ST_IDLE);
  assign w_last      = (r_sel == SEL_W'(NUM_GHOSTS - 1));
  assign w_start     = (r_state == ST_IDLE) && (tick || r_pending);
  // A tick is dropped only when a sweep is running and one is already queued.
  assign w_tick_acc  = tick && !(w_busy && r_pending);
  // In IDLE a queued sweep starts now, so a simultaneous tick is queued behind it.
  assign w_to_pend   = w_tick_acc && (w_busy || r_pending);
  assign w_enter_req = w_start || ((r_state == ST_UPD) && !w_last);

  ghost_mode_timer #(
    .SCATTER_TICKS (SCATTER_TICKS),
    .CHASE_TICKS   (CHASE_TICKS),
    .NUM_PHASES    (NUM_PHASES),
    .FRIGHT_TICKS  (FRIGHT_TICKS)
  ) u_mode_timer (
    .clk         (clk),
    .reset       (reset),
    .i_tick      (w_tick_acc),
    .i_pellet    (powerPellet),
    .o_tick_mode (w_tick_mode)
  );

`ifdef GHOST_FRIGHT_EN
  logic [15:0] r_lfsr;

  // Fright target source; advances once per ghost update.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_lfsr <= LFSR_SEED;
    end else if (r_state == ST_UPD) begin
      r_lfsr <= lfsr_step(r_lfsr);
    end
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and handshake/strobe outputs.
  always_comb begin
    w_next      = r_state;
    req         = 1'b0;
    ghostUpdate = '0;
    ghostDir    = 2'b00;
    unique case (r_state)
      ST_IDLE: begin
        if (tick || r_pending) w_next = ST_REQ;
      end
      ST_REQ: begin
        req = 1'b1;
        if (ack) w_next = ST_UPD;
      end
      ST_UPD: begin
        ghostUpdate = NUM_GHOSTS'(1) << r_sel;
        ghostDir    = r_dir;
        w_next      = w_last ? ST_IDLE : ST_REQ;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Sweep context: a starting sweep takes the queued snapshot if any, else the live tick.
  always_comb begin
    w_sw_mode  = r_cur_mode;
    w_sw_px    = r_cur_px;
    w_sw_py    = r_cur_py;
    w_next_sel = r_sel + 1'b1;
    if (r_state == ST_IDLE) begin
      w_next_sel = '0;
      if (r_pending) begin
        w_sw_mode = r_pend_mode;
        w_sw_px   = r_pend_px;
        w_sw_py   = r_pend_py;
      end else begin
        w_sw_mode = w_tick_mode;
        w_sw_px   = pacPosX;
        w_sw_py   = pacPosY;
      end
    end
  end

  assign w_corner = 2'(w_next_sel);

  // Target for the ghost about to be requested.
  always_comb begin
    w_tgt_x = COORD_W'(SCATTER_X[w_corner]);
    w_tgt_y = COORD_W'(SCATTER_Y[w_corner]);
    case (w_sw_mode)
      MODE_CHASE: begin
        w_tgt_x = w_sw_px;
        w_tgt_y = w_sw_py;
      end
`ifdef GHOST_FRIGHT_EN
      MODE_FRIGHT: begin
        w_tgt_x = r_lfsr[COORD_W-1:0];
        w_tgt_y = r_lfsr[15 -: COORD_W];
      end
`endif
      default: ;
    endcase
  end

  // Sweep bookkeeping: selection, targets, captured direction, queued tick, overrun.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sel       <= '0;
      r_tx        <= '0;
      r_ty        <= '0;
      r_cur_mode  <= MODE_SCATTER;
      r_cur_px    <= '0;
      r_cur_py    <= '0;
      r_pend_mode <= MODE_SCATTER;
      r_pend_px   <= '0;
      r_pend_py   <= '0;
      r_dir       <= DIR_UP;
      r_pending   <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_enter_req) begin
        r_sel <= w_next_sel;
        r_tx  <= w_tgt_x;
        r_ty  <= w_tgt_y;
      end
      if (w_start) begin
        r_cur_mode <= w_sw_mode;
        r_cur_px   <= w_sw_px;
        r_cur_py   <= w_sw_py;
      end
      if ((r_state == ST_REQ) && ack) begin
        r_dir <= dir_t'(dirIn);
      end
      if (w_to_pend) begin
        r_pending   <= 1'b1;
        r_pend_mode <= w_tick_mode;
        r_pend_px   <= pacPosX;
        r_pend_py   <= pacPosY;
      end else if (r_state == ST_IDLE) begin
        r_pending <= 1'b0;
      end
      if (tick && w_busy && r_pending) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign ghostSel   = r_sel;
  assign targetPosX = r_tx;
  assign targetPosY = r_ty;
  assign mode       = r_cur_mode;
  assign busy       = w_busy;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_ghost_scheduler.sv
// Directed bench for ghost_scheduler with short mode-timer parameters.
module tb_ghost_scheduler;

  localparam int NG = 4;
  localparam logic [1:0] MS = 2'b00;
  localparam logic [1:0] MC = 2'b01;
  localparam logic [1:0] MF = 2'b10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       powerPellet = 1'b0;
  logic       ack = 1'b0;
  logic [4:0] pacPosX = '0;
  logic [4:0] pacPosY = '0;
  logic [1:0] dirIn = '0;
  logic       req, busy, overrun;
  logic [1:0] ghostSel, ghostDir, mode;
  logic [4:0] targetPosX, targetPosY;
  logic [3:0] ghostUpdate;

  int checks = 0;
  int failures = 0;
  int upd_count = 0;
  int fright_seen = 0;
  int snap;

  int sx[4] = '{25, 2, 27, 0};
  int sy[4] = '{0, 0, 31, 31};

  typedef struct {
    logic [4:0] px;
    logic [4:0] py;
    int         ack_dly;
    logic [1:0] dbase;
    logic [1:0] mode_exp;
  } vec_t;

  vec_t vecs[8];

  ghost_scheduler #(
    .COORD_W       (5),
    .NUM_GHOSTS    (4),
    .SCATTER_TICKS (3),
    .CHASE_TICKS   (4),
    .NUM_PHASES    (1),
    .FRIGHT_TICKS  (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .powerPellet (powerPellet),
    .pacPosX     (pacPosX),
    .pacPosY     (pacPosY),
    .req         (req),
    .ack         (ack),
    .dirIn       (dirIn),
    .ghostSel    (ghostSel),
    .targetPosX  (targetPosX),
    .targetPosY  (targetPosY),
    .ghostUpdate (ghostUpdate),
    .ghostDir    (ghostDir),
    .mode        (mode),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ghostUpdate != '0) upd_count++;
    if (mode == MF) fright_seen++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick = 1'b0;
    powerPellet = 1'b0;
    ack = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // One full sweep from IDLE: tick, then per ghost wait for req, ack after ack_dly, check strobe.
  task automatic sweep(input logic pel, input logic [4:0] px, input logic [4:0] py,
                       input int ack_dly, input logic [1:0] dbase, input logic [1:0] mexp);
    int ex, ey, n;
    logic [1:0] d;
    tick = 1'b1;
    powerPellet = pel;
    pacPosX = px;
    pacPosY = py;
    @(negedge clk);
    tick = 1'b0;
    powerPellet = 1'b0;
    pacPosX = ~px;
    pacPosY = ~py;
    for (int g = 0; g < NG; g++) begin
      n = 0;
      while (!req && n < 10) begin
        @(negedge clk);
        n++;
      end
      if (!req) begin
        chk("req_timeout", 0, 1);
        return;
      end
      ex = (mexp == MC) ? int'(px) : sx[g];
      ey = (mexp == MC) ? int'(py) : sy[g];
      chk("sel", int'(ghostSel), g);
      chk("mode", int'(mode), int'(mexp));
      chk("busy", int'(busy), 1);
      if (mexp != MF) begin
        chk("tgt_x", int'(targetPosX), ex);
        chk("tgt_y", int'(targetPosY), ey);
      end
      for (int k = 1; k < ack_dly; k++) begin
        @(negedge clk);
        chk("req_hold", int'(req), 1);
        if (mexp != MF) chk("tgt_hold", int'(targetPosX), ex);
      end
      d = dbase + 2'(g);
      ack = 1'b1;
      dirIn = d;
      @(negedge clk);
      ack = 1'b0;
      dirIn = ~d;
      chk("upd", int'(ghostUpdate), 1 << g);
      chk("dir", int'(ghostDir), int'(d));
      chk("req_low", int'(req), 0);
      @(negedge clk);
    end
    chk("busy_end", int'(busy), 0);
    chk("upd_end", int'(ghostUpdate), 0);
  endtask

  initial begin
    vecs[0] = '{5'd3,  5'd4,  2, 2'd0, MS};
    vecs[1] = '{5'd10, 5'd20, 1, 2'd1, MS};
    vecs[2] = '{5'd31, 5'd0,  3, 2'd2, MS};
    vecs[3] = '{5'd7,  5'd9,  2, 2'd3, MC};
    vecs[4] = '{5'd0,  5'd31, 1, 2'd0, MC};
    vecs[5] = '{5'd15, 5'd16, 2, 2'd1, MC};
    vecs[6] = '{5'd1,  5'd2,  1, 2'd2, MC};
    vecs[7] = '{5'd30, 5'd29, 2, 2'd3, MC};

    // Reset values while reset is held.
    repeat (3) @(negedge clk);
    chk("rst_req", int'(req), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_sel", int'(ghostSel), 0);
    chk("rst_tx", int'(targetPosX), 0);
    chk("rst_ty", int'(targetPosY), 0);
    chk("rst_upd", int'(ghostUpdate), 0);
    chk("rst_dir", int'(ghostDir), 0);
    chk("rst_mode", int'(mode), 0);
    chk("rst_ovr", int'(overrun), 0);
    reset = 1'b1;
    @(negedge clk);

    // Sweeps through SCATTER x3 then CHASE held forever.
    snap = upd_count;
    foreach (vecs[i]) begin
      sweep(1'b0, vecs[i].px, vecs[i].py, vecs[i].ack_dly, vecs[i].dbase, vecs[i].mode_exp);
    end
    @(negedge clk);
    chk("table_pulses", upd_count - snap, 32);

    // Tick while busy queues one sweep; a further tick is dropped and flags overrun.
    do_reset();
    snap = upd_count;
    tick = 1'b1;
    pacPosX = 5'd1;
    pacPosY = 5'd2;
    @(negedge clk);
    @(negedge clk);
    chk("ovr_before", int'(overrun), 0);
    @(negedge clk);
    tick = 1'b0;
    chk("ovr_set", int'(overrun), 1);
    for (int n = 0; n < 60; n++) begin
      ack = req;
      dirIn = 2'b01;
      @(negedge clk);
    end
    ack = 1'b0;
    chk("two_sweeps", upd_count - snap, 8);
    chk("ovr_sticky", int'(overrun), 1);
    chk("idle_after", int'(busy), 0);
    // Two accepted ticks so far: the dropped one must not advance the timer.
    sweep(1'b0, 5'd4, 5'd5, 1, 2'd0, MS);
    sweep(1'b0, 5'd6, 5'd7, 1, 2'd1, MC);

    // Reset while waiting on ghost 2.
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    for (int n = 0; n < 40 && !(req && ghostSel == 2'd2); n++) begin
      ack = req;
      @(negedge clk);
    end
    ack = 1'b0;
    chk("t4_reach", int'(req && ghostSel == 2'd2), 1);
    snap = upd_count;
    reset = 1'b0;
    @(negedge clk);
    chk("t4_req", int'(req), 0);
    chk("t4_upd", int'(ghostUpdate), 0);
    chk("t4_busy", int'(busy), 0);
    chk("t4_sel", int'(ghostSel), 0);
    chk("t4_tx", int'(targetPosX), 0);
    chk("t4_ty", int'(targetPosY), 0);
    chk("t4_mode", int'(mode), 0);
    chk("t4_ovr", int'(overrun), 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("t4_no_pulse", upd_count - snap, 0);
    chk("t4_idle", int'(req), 0);

`ifdef GHOST_FRIGHT_EN
    // Pellet with tick: that sweep plus four more are FRIGHT, then the frozen timer resumes.
    do_reset();
    sweep(1'b0, 5'd2, 5'd3, 1, 2'd0, MS);
    sweep(1'b1, 5'd2, 5'd3, 1, 2'd0, MF);
    for (int i = 0; i < 4; i++) sweep(1'b0, 5'd2, 5'd3, 1, 2'd1, MF);
    sweep(1'b0, 5'd4, 5'd5, 1, 2'd2, MS);
    sweep(1'b0, 5'd4, 5'd5, 1, 2'd3, MS);
    sweep(1'b0, 5'd8, 5'd9, 1, 2'd0, MC);
`else
    // Pellets are ignored: no FRIGHT and the timer keeps its S,S,S,C count.
    do_reset();
    powerPellet = 1'b1;
    @(negedge clk);
    powerPellet = 1'b0;
    chk("pel_idle", int'(busy), 0);
    sweep(1'b1, 5'd2, 5'd3, 1, 2'd0, MS);
    sweep(1'b0, 5'd2, 5'd3, 1, 2'd1, MS);
    sweep(1'b1, 5'd2, 5'd3, 1, 2'd2, MS);
    sweep(1'b1, 5'd11, 5'd12, 1, 2'd3, MC);
    chk("no_fright", fright_seen, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
